// File: rtl/wb_select_pipe.sv
// Writeback source select feeding a 2-entry output FIFO with a registered head.
// Tracks delivered writebacks and flags out-of-range selects.

module wb_select_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] masked
);
  assign masked = (sel == SEL_W'(IDX)) ? data : '0;
endmodule

module wb_select_pipe #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     w,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         x,
  output logic                     sel_err,
  output logic [15:0]              wb_count
);
  localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);

  logic [NUM_SRC-1:0][WIDTH-1:0] lane_data;
  logic [NUM_SRC-1:0][WIDTH-1:0] lane_masked;
  logic [WIDTH-1:0]              pick;
  logic                          sel_oob;
  logic                          accept, push, pop;
  logic [1:0]                    occ;
  logic [WIDTH-1:0]              head, tail;

  assign lane_data = src_data;

  // One-hot lanes OR together; an out-of-range select matches no lane and yields zero.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    wb_select_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .sel    (sel),
      .data   (lane_data[i]),
      .masked (lane_masked[i])
    );
  end

  always_comb begin
    pick = '0;
    for (int i = 0; i < NUM_SRC; i++) pick |= lane_masked[i];
  end

  assign sel_oob   = ({1'b0, sel} >= NSRC);
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && w;
  assign pop       = out_valid && out_ready;
  assign x         = head;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      occ      <= 2'd0;
      head     <= '0;
      tail     <= '0;
      sel_err  <= 1'b0;
      wb_count <= 16'd0;
    end else begin
      if (pop) wb_count <= wb_count + 16'd1;
      if (push && sel_oob) sel_err <= 1'b1;
      // Push+pop only coexist at occupancy 1: in_ready blocks it at 2, out_valid at 0.
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= pick;
          else             tail <= pick;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) head <= tail;
          occ <= occ - 2'd1;
        end
        2'b11: head <= pick;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: expected writebacks queued at issue, checked by a monitor.
`timescale 1ns/1ps
module tb_wb_select_pipe;
  localparam int WIDTH = 8, NUM_SRC = 3, SEL_W = 2;

  logic                     sysclk = 0;
  logic                     rst = 1;
  logic [NUM_SRC*WIDTH-1:0] src_data = '0;
  logic [SEL_W-1:0]         sel = '0;
  logic                     w = 0;
  logic                     in_valid = 0;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready = 0;
  logic [WIDTH-1:0]         x;
  logic                     sel_err;
  logic [15:0]              wb_count;

  int n_cmp = 0, n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];

  wb_select_pipe #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
    .sysclk(sysclk), .rst(rst), .src_data(src_data), .sel(sel), .w(w),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .x(x), .sel_err(sel_err), .wb_count(wb_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every delivered writeback must match the oldest queued expectation.
  always @(negedge sysclk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got %0h expected none", x);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (x !== e) begin
          n_bad++;
          $display("FAIL sb_data: got %0h expected %0h", x, e);
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [SEL_W-1:0] s, input logic wen, input logic [WIDTH-1:0] val);
    logic [NUM_SRC*WIDTH-1:0] tmp;
    bit got;
    tmp = NUM_SRC*WIDTH'($urandom);
    if (int'(s) < NUM_SRC) tmp[int'(s)*WIDTH +: WIDTH] = val;
    src_data = tmp; sel = s; w = wen; in_valid = 1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge sysclk);
      if (in_ready) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance");
    end else if (wen) begin
      exp_q.push_back((int'(s) < NUM_SRC) ? val : '0);
    end
    @(posedge sysclk); #1;
    in_valid = 0; w = 0;
  endtask

  task automatic do_reset();
    @(posedge sysclk); #1;
    rst = 1;
    @(posedge sysclk); #1;
    rst = 0;
    exp_q.delete();
  endtask

  initial begin
    do_reset();
    @(negedge sysclk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_x", x, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_wb_count", wb_count, 0);
    @(posedge sysclk); #1;

    // Single push, immediate delivery, value held after drain
    out_ready = 1;
    send(2'd2, 1, 8'hA5);
    @(negedge sysclk);
    check("lat_x", x, 8'hA5);
    check("lat_out_valid", out_valid, 1);
    @(posedge sysclk); #1;
    check("drain_out_valid", out_valid, 0);
    check("drain_x_hold", x, 8'hA5);
    check("drain_wb_count", wb_count, 1);

    // Fill to two, third beat stalls until a pop
    out_ready = 0;
    send(2'd0, 1, 8'h11);
    send(2'd1, 1, 8'h22);
    @(negedge sysclk);
    check("full_in_ready", in_ready, 0);
    check("full_head", x, 8'h11);
    fork
      send(2'd2, 1, 8'h33);
      begin
        repeat (3) begin
          @(negedge sysclk);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge sysclk); #1;
        out_ready = 1;
      end
    join
    for (int k = 0; k < 20 && out_valid; k++) @(posedge sysclk);
    #1;
    check("order_wb_count", wb_count, 4);
    check("order_empty", out_valid, 0);

    // Simultaneous push and pop at occupancy 1
    out_ready = 0;
    send(2'd0, 1, 8'h11);
    out_ready = 1;
    send(2'd1, 1, 8'h44);
    @(negedge sysclk);
    check("pp_x", x, 8'h44);
    check("pp_out_valid", out_valid, 1);
    check("pp_in_ready", in_ready, 1);
    check("pp_wb_count", wb_count, 5);
    @(posedge sysclk); #1;
    check("pp_drain_count", wb_count, 6);

    // Out-of-range select delivers zero and sets the sticky flag
    send(2'd3, 1, 8'hEE);
    @(negedge sysclk);
    check("oob_x", x, 8'h00);
    check("oob_sel_err", sel_err, 1);
    @(posedge sysclk); #1;
    send(2'd3, 0, 8'hEE);
    @(negedge sysclk);
    check("w0_out_valid", out_valid, 0);
    check("w0_wb_count", wb_count, 7);
    check("w0_sel_err_sticky", sel_err, 1);
    check("w0_x_hold", x, 8'h00);
    @(posedge sysclk); #1;

    // Reset wins over a pending pop with two entries held
    out_ready = 0;
    send(2'd0, 1, 8'h55);
    send(2'd1, 1, 8'h66);
    out_ready = 1;
    rst = 1;
    @(posedge sysclk); #1;
    rst = 0;
    exp_q.delete();
    out_ready = 0;
    @(negedge sysclk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_x", x, 0);
    check("rst2_wb_count", wb_count, 0);
    check("rst2_sel_err", sel_err, 0);
    @(posedge sysclk); #1;

    // wb_count wrap: keep one entry resident and pop every cycle
    send(2'd0, 1, 8'h01);
    out_ready = 1;
    for (int i = 0; i < 65535; i++) send(2'(i % 3), 1, 8'(i));
    @(negedge sysclk);
    check("wrap_pre", wb_count, 16'hFFFF);
    check("wrap_pre_valid", out_valid, 1);
    @(posedge sysclk); #1;
    check("wrap_post", wb_count, 16'h0000);
    check("wrap_empty", out_valid, 0);
    check("sb_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_select_pipe.md
WB_SELECT_PIPE -- requirements
Module: wb_select_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the bit width of each writeback source and of the output.
REQ-002 The module SHALL have parameter NUM_SRC, default 4, meaning the number of writeback sources (legal range 2..16).
REQ-003 The module SHALL have parameter SEL_W, default 2, meaning the select width (SEL_W >= clog2(NUM_SRC)).
REQ-004 The module SHALL have one clock; reset is synchronous and active-high.
REQ-005 sysclk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 src_data  input  NUM_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  source index.
REQ-009 w  input  1  writeback enable; 1 = deliver selected value, 0 = consume the beat without output.
REQ-010 in_valid  input  1  upstream beat valid.
REQ-011 in_ready  output  1  module can accept a beat.
REQ-012 out_valid  output  1  x holds an undelivered writeback value.
REQ-013 out_ready  input  1  downstream accepts x.
REQ-014 x  output  WIDTH  head writeback value (registered).
REQ-015 sel_err  output  1  sticky flag: an accepted beat with w=1 had sel >= NUM_SRC.
REQ-016 wb_count  output  16  count of delivered writebacks.

Function
REQ-017 A beat SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-018 Storage SHALL be a 2-entry FIFO; in_ready = (occupancy < 2), driven from registered occupancy only (no combinational path from out_ready).
REQ-019 An accepted beat with w=1 SHALL push src_data[sel] (or all-zero when sel >= NUM_SRC) into the FIFO.
REQ-020 An accepted beat with w=0 SHALL push nothing; occupancy, x and wb_count are unchanged.
REQ-021 out_valid SHALL equal (occupancy > 0); x SHALL equal the head entry.
REQ-022 A pop SHALL occur when out_valid && out_ready at a rising edge; wb_count increments by 1 per pop, wrapping 0xFFFF -> 0x0000.
REQ-023 Latency: a value pushed at edge N SHALL present on x with out_valid=1 in the cycle after edge N when the FIFO was empty at edge N.
REQ-024 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with x taking the pushed value.
REQ-025 At occupancy 2, in_ready=0; a pop frees one slot, and in_ready=1 in the next cycle.
REQ-026 Pop with occupancy 0 and push with occupancy 2 SHALL be impossible by construction; occupancy never exceeds 2 or underflows.
REQ-027 When the FIFO empties, x SHALL hold the last popped value while out_valid=0.
REQ-028 sel_err SHALL set on any accepted w=1 beat with sel >= NUM_SRC and stay set until reset; w=0 beats never set it.
REQ-029 FIFO order SHALL be preserved: values leave in acceptance order.

Reset
REQ-030 While rst=1 at a rising edge: occupancy=0, out_valid=0, in_ready=1 in the following cycle, x=0, sel_err=0, wb_count=0, all entries cleared.
REQ-031 rst SHALL take priority over simultaneous push/pop; in-flight entries are discarded, with no pop counted.

Verification
REQ-032 Reset, then a push with sel=2, w=1, src2=0xA5 and out_ready=1 -> next cycle x=0xA5, out_valid=1; after the pop edge, out_valid=0, x=0xA5 held, wb_count=1.
REQ-033 out_ready=0, three back-to-back w=1 beats (0x11, 0x22, 0x33) -> in_ready=0 after the second beat, 0x33 not accepted until a pop; output order is 0x11, 0x22, 0x33.
REQ-034 Occupancy 1 (head 0x11), simultaneous push 0x44 and pop -> occupancy stays 1, x=0x44, wb_count +1.
REQ-035 NUM_SRC=3, push with sel=3, w=1 -> x=0x00 delivered, sel_err=1 sticky; a following sel=3, w=0 beat -> no push.
REQ-036 wb_count preset to 0xFFFF through 65535 pops, then one more pop -> wb_count=0x0000.
REQ-037 rst asserted with occupancy 2 and out_ready=1 -> next cycle occupancy 0, out_valid=0, x=0, wb_count unchanged from 0 (reset value).
